// File: rtl/window_pkg.sv
// Shared types and geometry constants for the window spill/fill engine.
package window_pkg;

  // Physical register file geometry.
  localparam int NUM_PHYS = 32;
  localparam int WIN_STEP = 4;
  localparam int WIN_REGS = 8;
  localparam int MAX_RES  = 7;

  // Derived widths and offsets.
  localparam int CWP_W = $clog2(NUM_PHYS);
  localparam int WC_W  = $clog2(WIN_STEP);
  // Lowest group of the oldest resident window, counted back from cwp.
  localparam int SPILL_BACK = (MAX_RES - 1) * WIN_STEP;
  // Group just below cwp, i.e. the part of the older window not shared with the current one.
  localparam int FILL_BACK = WIN_REGS - WIN_STEP;

  typedef enum logic [1:0] {
    WOP_NONE    = 2'b00,
    WOP_RESTORE = 2'b01,
    WOP_SAVE    = 2'b10,
    WOP_BAD     = 2'b11
  } win_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPILL,
    S_FILL,
    S_DONE,
    S_ERR
  } wsf_state_t;

endpackage

// File: rtl/window_spill_fill_if.sv
// Bundle of the control, register-file and memory signals of the spill/fill engine.
interface window_spill_fill_if;
  import window_pkg::*;

  // Control path
  logic             op_valid;
  win_op_t          op;
  logic             op_ready;
  logic             op_done;
  logic             op_err;
  logic [CWP_W-1:0] cwp;
  logic             win_full;

  // Physical register file port
  logic [CWP_W-1:0] rf_sel;
  logic [15:0]      rf_rdata;
  logic [15:0]      rf_wdata;
  logic             rf_we;

  // Memory controller port
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_we;
  logic             mem_re;
  logic             mem_ready;

  // The engine masters the register-file and memory transfers.
  modport master (
    input  op_valid, op, rf_rdata, mem_rdata, mem_ready,
    output op_ready, op_done, op_err, cwp, win_full,
           rf_sel, rf_wdata, rf_we, mem_addr, mem_wdata, mem_we, mem_re
  );

  // Control path, register file and memory controller side.
  modport slave (
    output op_valid, op, rf_rdata, mem_rdata, mem_ready,
    input  op_ready, op_done, op_err, cwp, win_full,
           rf_sel, rf_wdata, rf_we, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/window_spill_fill.sv
// Window spill/fill engine: tracks cwp and resident window count, spills the
// oldest 4-register group to a memory stack on SAVE when full, and fills it
// back on RESTORE when only one window is resident.
module window_spill_fill
  import window_pkg::*;
#(
  parameter logic [15:0] SPILL_BASE = 16'hF000,
  parameter int          MAX_DEPTH  = 64
) (
  input logic                 clock,
  input logic                 reset,
  window_spill_fill_if.master bus
);

  localparam int                 DEPTH_W    = $clog2(MAX_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [2:0]         RES_MAX    = 3'(MAX_RES);
  localparam logic [2:0]         RES_ONE    = 3'd1;
  localparam logic [CWP_W-1:0]   STEP       = CWP_W'(WIN_STEP);
  localparam logic [CWP_W-1:0]   SPILL_OFS  = CWP_W'(SPILL_BACK);
  localparam logic [CWP_W-1:0]   FILL_OFS   = CWP_W'(FILL_BACK);

  wsf_state_t         state, state_nxt;
  logic [CWP_W-1:0]   cwp, cwp_nxt;
  logic [2:0]         resident, resident_nxt;
  logic [DEPTH_W-1:0] depth, depth_nxt;
  logic [WC_W-1:0]    wc, wc_nxt;

  logic [DEPTH_W-1:0] slot;
  logic [15:0]        word_addr;
  logic               last_word;

  assign bus.cwp      = cwp;
  assign bus.win_full = (resident == RES_MAX);

  // Spill writes the next free slot; fill reads back the top occupied slot.
  assign slot      = (state == S_FILL) ? depth - DEPTH_ONE : depth;
  assign word_addr = SPILL_BASE + 16'({slot, wc});
  assign last_word = (wc == '1);

  // Next-state, counters, strobes and transfer addresses decoded from the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt     = state;
    cwp_nxt       = cwp;
    resident_nxt  = resident;
    depth_nxt     = depth;
    wc_nxt        = wc;
    bus.op_ready  = 1'b0;
    bus.op_done   = 1'b0;
    bus.op_err    = 1'b0;
    bus.rf_sel    = '0;
    bus.rf_wdata  = '0;
    bus.rf_we     = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;

    case (state)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          case (bus.op)
            WOP_NONE: state_nxt = S_DONE;
            WOP_SAVE: begin
              if (resident != RES_MAX) begin
                cwp_nxt      = cwp + STEP;
                resident_nxt = resident + RES_ONE;
                state_nxt    = S_DONE;
              end else if (depth == DEPTH_FULL) begin
                state_nxt = S_ERR;
              end else begin
                wc_nxt    = '0;
                state_nxt = S_SPILL;
              end
            end
            WOP_RESTORE: begin
              if (resident != RES_ONE) begin
                cwp_nxt      = cwp - STEP;
                resident_nxt = resident - RES_ONE;
                state_nxt    = S_DONE;
              end else if (depth == '0) begin
                state_nxt = S_ERR;
              end else begin
                wc_nxt    = '0;
                state_nxt = S_FILL;
              end
            end
            default: state_nxt = S_ERR;
          endcase
        end
      end

      S_SPILL: begin
        bus.rf_sel    = cwp - SPILL_OFS + CWP_W'(wc);
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.rf_rdata;
        bus.mem_addr  = word_addr;
        if (bus.mem_ready) begin
          wc_nxt = wc + 1'b1;
          if (last_word) begin
            depth_nxt = depth + DEPTH_ONE;
            cwp_nxt   = cwp + STEP;
            state_nxt = S_DONE;
          end
        end
      end

      S_FILL: begin
        bus.rf_sel   = cwp - FILL_OFS + CWP_W'(wc);
        bus.mem_re   = 1'b1;
        bus.mem_addr = word_addr;
        if (bus.mem_ready) begin
          bus.rf_we    = 1'b1;
          bus.rf_wdata = bus.mem_rdata;
          wc_nxt       = wc + 1'b1;
          if (last_word) begin
            depth_nxt = depth - DEPTH_ONE;
            cwp_nxt   = cwp - STEP;
            state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        bus.op_done = 1'b1;
        state_nxt   = S_IDLE;
      end

      S_ERR: begin
        bus.op_err = 1'b1;
        state_nxt  = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State registers; reset abandons any partial spill or fill on the same edge.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state    <= S_IDLE;
      cwp      <= '0;
      resident <= RES_ONE;
      depth    <= '0;
      wc       <= '0;
    end else begin
      state    <= state_nxt;
      cwp      <= cwp_nxt;
      resident <= resident_nxt;
      depth    <= depth_nxt;
      wc       <= wc_nxt;
    end
  end

endmodule

// File: tb/tb_window_spill_fill.sv
// Bench for window_spill_fill: directed test-plan steps, a randomized phase and
// depth boundaries, checked against a window/stack reference model.
module tb_window_spill_fill;
  import window_pkg::*;

  localparam logic [15:0] SPILL_BASE = 16'hF000;
  localparam int          MAX_DEPTH  = 64;

  typedef enum int {K_PLAIN, K_SPILL, K_FILL, K_ERR} kind_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  window_spill_fill_if bus ();

  window_spill_fill #(
    .SPILL_BASE(SPILL_BASE),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Environment: physical register file and spill memory
  logic [15:0] rf_arr  [32];
  logic [15:0] rf_seed [32];
  logic [15:0] mem_arr [256];
  logic        rf_load      = 1'b0;
  int          ready_mode   = 0;
  int          mem_busy_cyc = 0;
  int          bad_addr     = 0;
  logic [15:0] mem_off;

  assign mem_off       = bus.mem_addr - SPILL_BASE;
  assign bus.rf_rdata  = rf_arr[bus.rf_sel];
  assign bus.mem_rdata = bus.mem_re ? mem_arr[mem_off[7:0]] : 16'h0000;

  // mem_ready policy: 0 = always ready, 1 = random, 2 = stalled
  always @(negedge clock) begin
    case (ready_mode)
      0:       bus.mem_ready = 1'b1;
      1:       bus.mem_ready = ($urandom_range(0, 2) != 0);
      default: bus.mem_ready = 1'b0;
    endcase
  end

  always @(posedge clock) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf_arr[i] <= rf_seed[i];
    end else if (bus.rf_we) begin
      rf_arr[bus.rf_sel] <= bus.rf_wdata;
    end
    if (bus.mem_we && bus.mem_ready) begin
      mem_arr[mem_off[7:0]] <= bus.mem_wdata;
      if (mem_off > 16'd255) bad_addr <= bad_addr + 1;
    end
    if (bus.mem_we || bus.mem_re) mem_busy_cyc <= mem_busy_cyc + 1;
  end

  // Reference model: window count, resident count, stack of spilled groups
  int          m_win;
  int          m_res;
  logic [63:0] m_stack [$];
  logic [15:0] exp_rf  [32];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [4:0] phys(input int n);
    return 5'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_op_ready"},  32'(bus.op_ready),  1);
    chk({p, "_op_done"},   32'(bus.op_done),   0);
    chk({p, "_op_err"},    32'(bus.op_err),    0);
    chk({p, "_cwp"},       32'(bus.cwp),       0);
    chk({p, "_win_full"},  32'(bus.win_full),  0);
    chk({p, "_rf_sel"},    32'(bus.rf_sel),    0);
    chk({p, "_rf_we"},     32'(bus.rf_we),     0);
    chk({p, "_rf_wdata"},  32'(bus.rf_wdata),  0);
    chk({p, "_mem_we"},    32'(bus.mem_we),    0);
    chk({p, "_mem_re"},    32'(bus.mem_re),    0);
    chk({p, "_mem_addr"},  32'(bus.mem_addr),  0);
    chk({p, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
  endtask

  task automatic model_reset();
    m_win = 0;
    m_res = 1;
    m_stack.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_rf();
    for (int i = 0; i < 32; i++) begin
      rf_seed[i] = 16'($urandom);
      exp_rf[i]  = rf_seed[i];
    end
    @(negedge clock);
    rf_load = 1'b1;
    @(posedge clock);
    #1 rf_load = 1'b0;
  endtask

  // Issue one op; lat counts cycles from the accept edge to the completion pulse.
  task automatic do_op(input win_op_t o, input bit ghost, output int lat,
                       output bit got_done, output bit got_err);
    int w;
    w = 0;
    @(negedge clock);
    while (!bus.op_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("ready_before_op", 32'(bus.op_ready), 1);
    bus.op       = o;
    bus.op_valid = 1'b1;
    @(posedge clock);
    #1 bus.op_valid = ghost;
    lat      = 0;
    got_done = 1'b0;
    got_err  = 1'b0;
    while (!(got_done || got_err) && lat < 300) begin
      @(negedge clock);
      lat++;
      if (lat >= 2) bus.op_valid = 1'b0;
      got_done = bus.op_done;
      got_err  = bus.op_err;
    end
    bus.op_valid = 1'b0;
    chk("op_completes", 32'(got_done | got_err), 1);
    @(negedge clock);
    chk("pulse_one_cycle", 32'({bus.op_done, bus.op_err}), 0);
    chk("idle_after_op", 32'(bus.op_ready), 1);
  endtask

  task automatic run_op(input win_op_t o, input bit ghost, input bit exact_lat);
    kind_t       kind;
    int          lat;
    int          busy0;
    int          base;
    bit          got_done, got_err;
    logic [15:0] g [4];
    logic [63:0] grp;

    case (o)
      WOP_NONE: kind = K_PLAIN;
      WOP_SAVE: kind = (m_res < 7) ? K_PLAIN :
                       (m_stack.size() == MAX_DEPTH) ? K_ERR : K_SPILL;
      WOP_RESTORE: kind = (m_res > 1) ? K_PLAIN :
                          (m_stack.size() == 0) ? K_ERR : K_FILL;
      default: kind = K_ERR;
    endcase

    busy0 = mem_busy_cyc;
    do_op(o, ghost && (kind == K_SPILL || kind == K_FILL), lat, got_done, got_err);
    chk("done_flag", 32'(got_done), 32'(kind != K_ERR));
    chk("err_flag",  32'(got_err),  32'(kind == K_ERR));

    if (kind == K_PLAIN || kind == K_ERR) begin
      chk("latency_short", lat, 1);
      chk("no_mem_traffic", mem_busy_cyc, busy0);
    end else if (exact_lat) begin
      chk("latency_xfer", lat, 5);
    end else begin
      chk("latency_xfer_min", 32'(lat >= 5), 1);
    end

    if (kind == K_PLAIN && o == WOP_SAVE) begin
      m_win++;
      m_res++;
    end else if (kind == K_PLAIN && o == WOP_RESTORE) begin
      m_win--;
      m_res--;
    end else if (kind == K_SPILL) begin
      base = 4 * m_stack.size();
      for (int i = 0; i < 4; i++) begin
        g[i] = exp_rf[phys(4 * m_win - 24 + i)];
        chk($sformatf("spill_word_%0d", base + i), 32'(mem_arr[base + i]), 32'(g[i]));
      end
      m_stack.push_back({g[3], g[2], g[1], g[0]});
      m_win++;
    end else if (kind == K_FILL) begin
      grp = m_stack.pop_back();
      for (int i = 0; i < 4; i++) begin
        g[i] = grp[16*i +: 16];
        chk($sformatf("fill_reg_%0d", phys(4 * m_win - 4 + i)),
            32'(rf_arr[phys(4 * m_win - 4 + i)]), 32'(g[i]));
        exp_rf[phys(4 * m_win - 4 + i)] = g[i];
      end
      m_win--;
    end

    chk("cwp", 32'(bus.cwp), 32'(phys(4 * m_win)));
    chk("win_full", 32'(bus.win_full), 32'(m_res == 7));
  endtask

  // Watchdog: the run must end on its own
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r;
    win_op_t     o;

    bus.op_valid = 1'b0;
    bus.op       = WOP_NONE;
    ready_mode   = 0;

    // Reset state
    do_reset();
    check_reset_vals("reset");
    load_rf();

    // RESTORE straight after reset underflows without memory traffic
    run_op(WOP_RESTORE, 1'b0, 1'b1);
    chk("underflow_cwp", 32'(bus.cwp), 0);

    // Six plain SAVEs fill the physical file
    for (int i = 0; i < 6; i++) run_op(WOP_SAVE, 1'b0, 1'b1);
    chk("six_saves_cwp", 32'(bus.cwp), 24);
    chk("six_saves_full", 32'(bus.win_full), 1);
    chk("six_saves_no_mem", mem_busy_cyc, 0);

    // 7th SAVE spills registers 0..3, 8th spills 4..7 with a busy-time request ignored
    run_op(WOP_SAVE, 1'b0, 1'b1);
    chk("spill1_cwp", 32'(bus.cwp), 28);
    for (int i = 0; i < 4; i++)
      chk($sformatf("spill1_mem_%0d", i), 32'(mem_arr[i]), 32'(rf_seed[i]));
    run_op(WOP_SAVE, 1'b1, 1'b1);
    chk("spill2_cwp_wrap", 32'(bus.cwp), 0);

    // Six plain RESTOREs, scramble the file, then a fill restores registers 4..7
    for (int i = 0; i < 6; i++) run_op(WOP_RESTORE, 1'b0, 1'b1);
    chk("restores_cwp", 32'(bus.cwp), 8);
    chk("restores_not_full", 32'(bus.win_full), 0);
    load_rf();
    run_op(WOP_RESTORE, 1'b0, 1'b1);
    chk("fill_cwp", 32'(bus.cwp), 4);
    for (int i = 0; i < 32; i++)
      chk($sformatf("rf_after_fill_%0d", i), 32'(rf_arr[i]), 32'(exp_rf[i]));

    // Randomized ops with random memory stalls
    do_reset();
    ready_mode = 1;
    load_rf();
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      o = (r < 5) ? WOP_SAVE : (r < 8) ? WOP_RESTORE : (r == 8) ? WOP_NONE : WOP_BAD;
      run_op(o, ($urandom_range(0, 1) == 1), 1'b0);
      if ($urandom_range(0, 9) == 0) load_rf();
    end

    // Depth boundaries: fill the spill stack, overflow, drain it, underflow
    do_reset();
    ready_mode = 0;
    load_rf();
    for (int i = 0; i < 6 + MAX_DEPTH; i++) run_op(WOP_SAVE, 1'b0, 1'b1);
    chk("stack_full_size", m_stack.size(), MAX_DEPTH);
    run_op(WOP_SAVE, 1'b0, 1'b1);
    for (int i = 0; i < 6 + MAX_DEPTH; i++) run_op(WOP_RESTORE, 1'b0, 1'b1);
    run_op(WOP_RESTORE, 1'b0, 1'b1);
    chk("drained_cwp", 32'(bus.cwp), 0);

    // Stalled spill keeps address and data stable, then reset mid-spill
    do_reset();
    ready_mode = 0;
    load_rf();
    for (int i = 0; i < 6; i++) run_op(WOP_SAVE, 1'b0, 1'b1);
    ready_mode = 2;
    repeat (2) @(negedge clock);
    bus.op       = WOP_SAVE;
    bus.op_valid = 1'b1;
    @(posedge clock);
    #1 bus.op_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("stall_mem_we_%0d", c),    32'(bus.mem_we),    1);
      chk($sformatf("stall_rf_sel_%0d", c),    32'(bus.rf_sel),    0);
      chk($sformatf("stall_mem_addr_%0d", c),  32'(bus.mem_addr),  32'(SPILL_BASE));
      chk($sformatf("stall_mem_wdata_%0d", c), 32'(bus.mem_wdata), 32'(exp_rf[0]));
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_vals("mid_spill_reset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    ready_mode = 0;
    run_op(WOP_RESTORE, 1'b0, 1'b1);
    run_op(WOP_SAVE, 1'b0, 1'b1);
    chk("after_reset_save_cwp", 32'(bus.cwp), 4);

    chk("spill_addr_range", bad_addr, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/window_spill_fill.md
# window_spill_fill

Spill/fill engine that manages the memory-backed side of the windowed register file. Processor window operations (save/restore) are issued here. The block tracks the current window pointer and the number of resident windows. It saves the oldest 4-register group to a memory spill stack when the physical file is full, and restores a group from memory when a restore would expose a non-resident window. It sits between the control path, the register file's physical read/write port and the memory controller.

## Interface
Parameters:
- SPILL_BASE, 16'hF000, memory word address of spill-stack slot 0
- MAX_DEPTH, 64, maximum number of spilled 4-register groups

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  window operation request
- op  in  2  window_pkg::win_op_t: 2'b10 SAVE, 2'b01 RESTORE, 2'b00 NONE, 2'b11 BAD
- op_ready  out  1  high only in IDLE; requests are accepted only when op_valid && op_ready
- op_done  out  1  one-cycle pulse when an operation completes successfully
- op_err  out  1  one-cycle pulse on overflow, underflow or BAD
- cwp  out  5  current window base, a physical register index and always a multiple of 4
- win_full  out  1  high when resident == 7
- rf_sel  out  5  physical register select, for both read and write
- rf_rdata  in  16  physical register read data; combinational from rf_sel
- rf_wdata  out  16  physical register write data
- rf_we  out  1  physical register write strobe
- mem_addr  out  16  memory word address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid when mem_ready is high
- mem_we  out  1  memory write request
- mem_re  out  1  memory read request
- mem_ready  in  1  memory handshake; the transfer completes on a cycle where the request and mem_ready are both high

## Operation
- Geometry:
  - 32 physical registers; each window spans 8 registers; adjacent windows overlap by 4.
  - At most 7 windows are resident.
  - All physical indices are computed mod 32, and 5-bit arithmetic wraps naturally.
- Internal state:
  - cwp (5b)
  - resident (3b, range 1..7)
  - depth (0..MAX_DEPTH)
  - word counter wc (2b)
  - FSM state
- FSM states: IDLE, SPILL, FILL, DONE, ERR.
- IDLE, on an accepted request:
  - NONE → DONE. Nothing changes.
  - BAD → ERR. Nothing changes.
  - SAVE, resident < 7 → DONE, with cwp += 4 and resident += 1.
  - SAVE, resident == 7, depth == MAX_DEPTH → ERR (overflow).
  - SAVE, resident == 7, depth < MAX_DEPTH → SPILL, wc = 0.
  - RESTORE, resident > 1 → DONE, with cwp -= 4 and resident -= 1.
  - RESTORE, resident == 1, depth == 0 → ERR (underflow).
  - RESTORE, resident == 1, depth > 0 → FILL, wc = 0.
- SPILL:
  - Each transfer: rf_sel = cwp − 24 + wc, mem_we = 1, mem_wdata = rf_rdata, mem_addr = SPILL_BASE + 4·depth + wc.
  - On mem_ready: wc += 1.
  - After the wc == 3 transfer: depth += 1, cwp += 4 (resident unchanged at 7), → DONE.
- FILL:
  - Each transfer: mem_re = 1, mem_addr = SPILL_BASE + 4·(depth−1) + wc.
  - On mem_ready: rf_we = 1, rf_sel = cwp − 4 + wc, rf_wdata = mem_rdata (same cycle).
  - After the wc == 3 transfer: depth −= 1, cwp −= 4 (resident unchanged at 1), → DONE.
- DONE: op_done = 1, → IDLE.
- ERR: op_err = 1, → IDLE.
- Strobes: mem_we, mem_re, rf_we, op_done and op_err are decoded from state. mem_we and mem_re stay high for the whole of a stalled transfer.
- Idle values:
  - mem_addr, mem_wdata and rf_wdata are 0 when their strobe is low.
  - rf_sel is 0 outside SPILL/FILL.

## Timing
- Reset values: state IDLE, cwp 0, resident 1, depth 0, wc 0, op_ready 1, win_full 0. All strobes, op_done, op_err, rf_sel, addresses and data are 0.
- Latency, measured from the accept edge to the op_done pulse:
  - Non-spilling SAVE/RESTORE and NONE: op_done is high during the cycle after the accept edge.
  - SPILL or FILL: 4 transfers at ≥1 cycle each, then 1 DONE cycle. Minimum 5 cycles after the accept edge.
- op_valid while op_ready is low is ignored and not queued.
- mem_ready held low stalls the current transfer indefinitely. Address and data stay stable while stalled.
- mem_ready is ignored when no request is asserted.
- Reset asserted mid-SPILL/FILL: at that edge everything returns to reset values. The partial transfer is discarded and any memory words already written are abandoned.
- cwp, win_full and resident update on the same edge the FSM leaves IDLE (no spill case) or leaves SPILL/FILL.

## Structure
- window_pkg holds:
  - win_op_t (WOP_NONE, WOP_RESTORE, WOP_SAVE, WOP_BAD)
  - wsf_state_t
  - constants NUM_PHYS = 32, WIN_STEP = 4, WIN_REGS = 8, MAX_RES = 7
- No sub-module: the word counter and address adders stay inline. The single FSM is in one always_ff block plus one always_comb block for strobes and addresses.

## Test plan
- Reset, then 6 SAVEs → each op_done arrives 1 cycle after accept. cwp ends at 24, resident 7, win_full 1, no mem_we.
- 7th SAVE with mem_ready tied to 1:
  - rf_sel 0,1,2,3 are written to SPILL_BASE+0..3 with rf_rdata values.
  - Then cwp 28, depth 1; op_done pulses 5 cycles after accept.
- 8th SAVE → spills registers 4..7 to SPILL_BASE+4..7. cwp wraps 28→0, depth 2.
- Then 6 RESTOREs → cwp 8, resident 1. The next RESTORE:
  - reads SPILL_BASE+4..7 and writes registers 4..7 with rf_we;
  - ends with cwp 4, depth 1.
- RESTORE immediately after reset → op_err pulse, no memory traffic, cwp 0.
- During a spill, hold mem_ready low 3 cycles → mem_addr and mem_wdata stay stable. Then assert reset mid-spill → all reset values on the next cycle.
